// File: rtl/nic_pkg.sv
// Shared constants for the ring NIC: CPU-side register map and status bit positions.
package nic_pkg;

  localparam logic [1:0] NIC_IN_BUF   = 2'b00;
  localparam logic [1:0] NIC_IN_STAT  = 2'b01;
  localparam logic [1:0] NIC_OUT_BUF  = 2'b10;
  localparam logic [1:0] NIC_OUT_STAT = 2'b11;

  // Status bit positions counted from the least-significant end of the word;
  // on the big-endian [0:W-1] bus the actual index is W-1-<position>.
  localparam int FULL_BIT = 0;
  localparam int DROP_BIT = 1;

endpackage

// File: rtl/nic_channel_buffer.sv
// One-entry packet buffer with full flag; a push while full is refused and
// reported on the combinational drop pulse.
module nic_channel_buffer #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [0:WIDTH-1] d_in,
  output logic [0:WIDTH-1] data,
  output logic             full,
  output logic             drop
);

  always_ff @(posedge clk) begin
    if (reset) begin
      data <= '0;
      full <= 1'b0;
    end else if (push && !full) begin
      data <= d_in;
      full <= 1'b1;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

  // A push that coincides with a pop still sees the old full flag and is refused.
  assign drop = push & full;

endmodule

// File: rtl/nic_ring_interface.sv
// CPU-to-ring NIC: two one-entry channel buffers behind a 4-location register
// file, with polarity-gated injection and a sticky output drop flag.
module nic_ring_interface
  import nic_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 2,
  parameter int VC_BIT     = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [0:DATA_WIDTH-1] d_in,
  output logic [0:DATA_WIDTH-1] d_out,
  input  logic                  nicEn,
  input  logic                  nicWrEn,
  input  logic                  net_si,
  output logic                  net_ri,
  input  logic [0:DATA_WIDTH-1] net_di,
  output logic                  net_so,
  input  logic                  net_ro,
  output logic [0:DATA_WIDTH-1] net_do,
  input  logic                  net_polarity
);

  logic [0:DATA_WIDTH-1] in_data, out_data;
  logic                  in_full, out_full;
  logic                  in_drop_unused, out_drop;
  logic                  drop_flag;
  logic                  cpu_rd, cpu_wr;
  logic                  in_push, in_pop, out_push;
  logic [0:DATA_WIDTH-1] in_stat, out_stat;

  assign cpu_rd   = nicEn & ~nicWrEn;
  assign cpu_wr   = nicEn & nicWrEn;

  assign net_ri   = ~in_full;
  assign in_push  = net_si & net_ri;
  assign in_pop   = cpu_rd && (addr == NIC_IN_BUF);
  assign out_push = cpu_wr && (addr == NIC_OUT_BUF);

  assign net_so   = out_full & net_ro & (out_data[VC_BIT] == net_polarity);
  assign net_do   = out_data;

  nic_channel_buffer #(.WIDTH(DATA_WIDTH)) u_in_buf (
    .clk   (clk),
    .reset (reset),
    .push  (in_push),
    .pop   (in_pop),
    .d_in  (net_di),
    .data  (in_data),
    .full  (in_full),
    .drop  (in_drop_unused)
  );

  nic_channel_buffer #(.WIDTH(DATA_WIDTH)) u_out_buf (
    .clk   (clk),
    .reset (reset),
    .push  (out_push),
    .pop   (net_so),
    .d_in  (d_in),
    .data  (out_data),
    .full  (out_full),
    .drop  (out_drop)
  );

  // Read-to-clear: the status read returns the flag value before the clear.
  always_ff @(posedge clk) begin
    if (reset)
      drop_flag <= 1'b0;
    else if (out_drop)
      drop_flag <= 1'b1;
    else if (cpu_rd && (addr == NIC_OUT_STAT))
      drop_flag <= 1'b0;
  end

  always_comb begin
    in_stat  = '0;
    out_stat = '0;
    in_stat[DATA_WIDTH-1-FULL_BIT]  = in_full;
    out_stat[DATA_WIDTH-1-FULL_BIT] = out_full;
    out_stat[DATA_WIDTH-1-DROP_BIT] = drop_flag;
  end

  always_comb begin
    d_out = '0;
    if (cpu_rd) begin
      case (addr)
        NIC_IN_BUF:   d_out = in_data;
        NIC_IN_STAT:  d_out = in_stat;
        NIC_OUT_STAT: d_out = out_stat;
        default:      d_out = '0;
      endcase
    end
  end

endmodule

// File: doc/nic_ring_interface.md
Name: nic_ring_interface

Overview:
- Network interface controller between one `cpu` node and its ring router port in the Cardinal bidirectional ring NoC.
- Exposes two one-entry channel buffers to the CPU as a 4-location register file via the CPU's NIC port (nicAddr/nicEn/nicWrEn).
- Sequences packet injection into the router under ready/polarity gating.
- Accepts packets ejected by the router under ready/valid handshake.

Parameters:
- DATA_WIDTH, 64, packet and CPU data width (big-endian [0:DATA_WIDTH-1]).
- ADDR_WIDTH, 2, CPU-side register address width.
- VC_BIT, 0, packet bit index carrying the virtual-channel tag compared against net_polarity.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- addr  in  ADDR_WIDTH  CPU register select (driven by cpu nicAddr).
- d_in  in  DATA_WIDTH  CPU write data (cpu nicDataOut).
- d_out  out  DATA_WIDTH  CPU read data (cpu nicDataIn), combinational.
- nicEn  in  1  CPU access enable.
- nicWrEn  in  1  1 = write, 0 = read; ignored when nicEn=0.
- net_si  in  1  router-to-NIC packet valid.
- net_ri  out  1  NIC ready to accept router packet.
- net_di  in  DATA_WIDTH  router-to-NIC packet.
- net_so  out  1  NIC-to-router packet valid.
- net_ro  in  1  router ready to accept injection.
- net_do  out  DATA_WIDTH  NIC-to-router packet.
- net_polarity  in  1  router cycle polarity.

Behaviour:
- Address map:
  - 2'b00 input buffer (read only).
  - 2'b01 input status (read only).
  - 2'b10 output buffer (write only).
  - 2'b11 output status (read only).
- Status word layout:
  - Bit DATA_WIDTH-1 = full flag.
  - Output status bit DATA_WIDTH-2 = sticky drop flag.
  - All other status bits read 0.
- Reset: both buffers empty and data 0; drop flag 0; net_ri=1, net_so=0, net_do=0, d_out=0.
- Input channel:
  - net_ri = ~in_full.
  - On a clock edge with net_si & net_ri: in_data <= net_di, in_full <= 1.
  - net_si while net_ri=0 is ignored; the router holds the packet.
- CPU read of 2'b00 (nicEn=1, nicWrEn=0):
  - d_out = in_data in the same cycle.
  - If in_full, clear in_full at that edge.
  - Reading while empty returns the stale in_data and changes no state.
- Read/accept collision: the input buffer holds no bypass. When full, net_ri=0, so a clearing read and a router write never land on the same edge. The next accept happens no earlier than the cycle after the clearing read.
- Output channel:
  - CPU write to 2'b10 (nicEn=1, nicWrEn=1) with out_full=0: out_data <= d_in, out_full <= 1.
  - Write while out_full=1: out_data unchanged; drop flag <= 1.
- Drop flag clears only on a CPU read of 2'b11 (clear at that edge; the read returns the pre-clear value) or on reset.
- Injection:
  - net_so = out_full & net_ro & (out_data[VC_BIT] == net_polarity).
  - net_do = out_data at all times.
  - On an edge with net_so=1, out_full <= 0.
- Inject/write collision: a write in the same cycle as net_so=1 sees out_full=1 and is dropped, setting the drop flag. The CPU must poll status.
- Invalid or inactive accesses:
  - Write to 2'b00/2'b01/2'b11 and read of 2'b10 have no effect; d_out = 0 for a 2'b10 read.
  - nicEn=0: d_out = 0, no state change.
- Latency:
  - Router packet visible to the CPU one cycle after the handshake edge.
  - CPU write eligible for injection on the cycle after the write edge.
- Reset mid-operation: any buffered packet is discarded; the router must re-send packets it believes undelivered. No handshake is in flight across reset.

Decomposition:
- Package nic_pkg:
  - Address constants NIC_IN_BUF=2'b00, NIC_IN_STAT=2'b01, NIC_OUT_BUF=2'b10, NIC_OUT_STAT=2'b11.
  - Status bit position constants FULL_BIT, DROP_BIT.
- Sub-module nic_channel_buffer: one-entry register with full flag, push/pop inputs, and a push-when-full drop pulse output. Instantiated twice (input and output channels). The top level holds the address decode, polarity gating and drop flag.

Test Plan:
- Reset, then read 2'b01 and 2'b11 → both read 64'h0; net_ri=1, net_so=0.
- Router writes 64'h0000_0000_0000_00A5 with net_si=1 → next cycle net_ri=0 and status 2'b01 = 64'h1; a read of 2'b00 returns 64'hA5, and the cycle after, net_ri=1 and status = 0.
- CPU writes 64'h8000_0000_0000_0001 (VC bit=1) with net_ro=1, net_polarity=0 → net_so stays 0. Set polarity=1 → net_so=1 for one cycle with net_do=that word, then out status = 0.
- Two consecutive CPU writes 64'h11 and 64'h22 while net_ro=0 → net_do holds 64'h11; 2'b11 reads 64'h3; a second read of 2'b11 reads 64'h1.
- net_si held high while the input buffer is full for 5 cycles → no overwrite; after a CPU read, the pending packet is accepted exactly once.
- Reset asserted with both buffers full → next cycle net_ri=1, net_so=0, both status reads = 0.
